// File: rtl/demux4_router.sv
// -----------------------------------------------------------------------------
// demux4_router
//
// Purpose:
//   Steers a single valid/ready input stream to one of four destinations
//   (a, b, c, d) selected by a 2-bit code. This is the reverse counterpart of
//   the CPU's 4-way select mux. Each destination owns a one-entry register
//   buffer, so every output is registered and each consumer applies its own
//   back-pressure without stalling the other destinations.
//
// Configuration macro:
//   DEMUX4_STATS_EN - when defined, adds one accepted-transfer counter per
//                     destination (cnt_a..cnt_d, CNT_WIDTH bits, wrapping).
//                     When undefined, the counter ports and logic are absent.
//
// Parameters:
//   SIZE      - payload width in bits for the input and every output
//   CNT_WIDTH - width of each per-destination transfer counter
//
// Ports:
//   clk                      - single clock, all state changes on rising edge
//   rst                      - synchronous, active-high reset
//   in_data   [SIZE-1:0]     - payload to route
//   in_sel    [1:0]          - destination: 0=a, 1=b, 2=c, 3=d
//   in_valid                 - producer presents a payload
//   in_ready                 - router accepts the payload this cycle
//   out_k_data [SIZE-1:0]    - buffered payload for destination k
//   out_k_valid              - buffer k holds a payload
//   out_k_ready              - consumer k takes the payload this cycle
//   cnt_k [CNT_WIDTH-1:0]    - accepted-transfer count for k (stats build only)
// -----------------------------------------------------------------------------
module demux4_router #(
    parameter int SIZE      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [SIZE-1:0]      in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,

    output logic [SIZE-1:0]      out_a_data,
    output logic                 out_a_valid,
    output logic [SIZE-1:0]      out_b_data,
    output logic                 out_b_valid,
    output logic [SIZE-1:0]      out_c_data,
    output logic                 out_c_valid,
    output logic [SIZE-1:0]      out_d_data,
    output logic                 out_d_valid,

`ifdef DEMUX4_STATS_EN
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b,
    output logic [CNT_WIDTH-1:0] cnt_c,
    output logic [CNT_WIDTH-1:0] cnt_d,
`endif

    input  logic                 out_a_ready,
    input  logic                 out_b_ready,
    input  logic                 out_c_ready,
    input  logic                 out_d_ready
);

    // Elaboration-time sanity checks on the configuration.
    if (SIZE < 1) begin : g_bad_size
        $error("demux4_router: SIZE must be at least 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("demux4_router: CNT_WIDTH must be at least 1");
    end

    // Per-destination state, indexed 0=a, 1=b, 2=c, 3=d.
    logic [3:0]      buf_valid;
    logic [SIZE-1:0] buf_data [4];

    logic [3:0] out_ready_vec;
    logic [3:0] sel_dec;
    logic [3:0] buf_free;
    logic [3:0] load;
    logic [3:0] drain;
    logic       accept;

    assign out_ready_vec = {out_d_ready, out_c_ready, out_b_ready, out_a_ready};

    // One-hot decode of the destination; every encoding is legal.
    always_comb begin
        sel_dec = 4'b0000;
        case (in_sel)
            2'd0:    sel_dec = 4'b0001;
            2'd1:    sel_dec = 4'b0010;
            2'd2:    sel_dec = 4'b0100;
            default: sel_dec = 4'b1000;
        endcase
    end

    // A buffer can take a new word if it is empty or is being drained on this
    // same edge. Folding the drain into "free" is what allows one transfer
    // per cycle into a single destination.
    assign buf_free = ~buf_valid | out_ready_vec;

    // in_ready deliberately ignores in_valid so the producer can rely on it
    // without a combinational loop through its own valid.
    assign in_ready = !rst && buf_free[in_sel];
    assign accept   = in_valid && in_ready;

    assign load  = accept ? sel_dec : 4'b0000;
    assign drain = buf_valid & out_ready_vec;

    // Buffer registers. A load wins over a drain on the same destination, so
    // valid stays set and the data is replaced. Data is left untouched by a
    // drain and only changes on a load or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                buf_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    buf_valid[k] <= 1'b1;
                    buf_data[k]  <= in_data;
                end else if (drain[k]) begin
                    buf_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_a_data  = buf_data[0];
    assign out_b_data  = buf_data[1];
    assign out_c_data  = buf_data[2];
    assign out_d_data  = buf_data[3];
    assign out_a_valid = buf_valid[0];
    assign out_b_valid = buf_valid[1];
    assign out_c_valid = buf_valid[2];
    assign out_d_valid = buf_valid[3];

`ifdef DEMUX4_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [4];

    // Counters follow accepts only; drains do not touch them and they wrap
    // naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign cnt_a = cnt_q[0];
    assign cnt_b = cnt_q[1];
    assign cnt_c = cnt_q[2];
    assign cnt_d = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4_router.sv
// -----------------------------------------------------------------------------
// tb_demux4_router
//
// Purpose:
//   Self-checking bench for demux4_router. A small reference model tracks the
//   expected valid/data of each destination buffer, and per-destination
//   scoreboard queues hold accepted payloads until the model predicts their
//   drain, at which point the DUT output is compared to the queue head.
//
// Configuration macro:
//   DEMUX4_STATS_EN - when defined, the counter ports are connected and the
//                     per-destination counters are checked as well.
// -----------------------------------------------------------------------------
module tb_demux4_router;

    localparam int SIZE      = 32;
    localparam int CNT_WIDTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] out_a_data, out_b_data, out_c_data, out_d_data;
    logic            out_a_valid, out_b_valid, out_c_valid, out_d_valid;
    logic            out_a_ready, out_b_ready, out_c_ready, out_d_ready;
`ifdef DEMUX4_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    always #5 clk = ~clk;

    demux4_router #(
        .SIZE      (SIZE),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_c_data  (out_c_data),
        .out_c_valid (out_c_valid),
        .out_d_data  (out_d_data),
        .out_d_valid (out_d_valid),
`ifdef DEMUX4_STATS_EN
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b),
        .cnt_c       (cnt_c),
        .cnt_d       (cnt_d),
`endif
        .out_a_ready (out_a_ready),
        .out_b_ready (out_b_ready),
        .out_c_ready (out_c_ready),
        .out_d_ready (out_d_ready)
    );

    // Indexed views of the DUT outputs (0=a .. 3=d).
    logic [3:0]      obs_valid;
    logic [SIZE-1:0] obs_data [4];
    assign obs_valid   = {out_d_valid, out_c_valid, out_b_valid, out_a_valid};
    assign obs_data[0] = out_a_data;
    assign obs_data[1] = out_b_data;
    assign obs_data[2] = out_c_data;
    assign obs_data[3] = out_d_data;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [3:0]           exp_valid;
    logic [SIZE-1:0]      exp_data [4];
    logic [CNT_WIDTH-1:0] exp_cnt  [4];

    // Scoreboard: accepted payloads awaiting drain, one queue per destination.
    logic [SIZE-1:0] q_a[$], q_b[$], q_c[$], q_d[$];

    task automatic checkOutput(input string tag, input logic [SIZE-1:0] observed,
                               input logic [SIZE-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic sbPush(input int k, input logic [SIZE-1:0] v);
        case (k)
            0:       q_a.push_back(v);
            1:       q_b.push_back(v);
            2:       q_c.push_back(v);
            default: q_d.push_back(v);
        endcase
    endtask

    task automatic sbPop(input int k, output logic [SIZE-1:0] v);
        v = 'x;
        case (k)
            0:       if (q_a.size() > 0) v = q_a.pop_front();
            1:       if (q_b.size() > 0) v = q_b.pop_front();
            2:       if (q_c.size() > 0) v = q_c.pop_front();
            default: if (q_d.size() > 0) v = q_d.pop_front();
        endcase
    endtask

    // Drives one cycle of stimulus, checks in_ready and any predicted drains
    // before the edge, advances the model at the edge and checks every
    // registered output shortly after it.
    task automatic applyStimulus(input logic r, input logic [1:0] sel,
                                 input logic [SIZE-1:0] data, input logic valid,
                                 input logic [3:0] rdy);
        logic            exp_ready;
        logic            acc;
        logic [SIZE-1:0] head;
        @(negedge clk);
        rst         = r;
        in_sel      = sel;
        in_data     = data;
        in_valid    = valid;
        out_a_ready = rdy[0];
        out_b_ready = rdy[1];
        out_c_ready = rdy[2];
        out_d_ready = rdy[3];
        #1;
        exp_ready = !r && (!exp_valid[sel] || rdy[sel]);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                if (exp_valid[k] && rdy[k]) begin
                    sbPop(k, head);
                    checkOutput($sformatf("drain_data_%0d", k), obs_data[k], head);
                end
            end
        end
        acc = valid && exp_ready;
        if (acc) sbPush(int'(sel), data);
        @(posedge clk);
        if (r) begin
            exp_valid = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                exp_data[k] = '0;
                exp_cnt[k]  = '0;
            end
            q_a.delete();
            q_b.delete();
            q_c.delete();
            q_d.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && int'(sel) == k) begin
                    exp_valid[k] = 1'b1;
                    exp_data[k]  = data;
                    exp_cnt[k]   = exp_cnt[k] + 1'b1;
                end else if (exp_valid[k] && rdy[k]) begin
                    exp_valid[k] = 1'b0;
                end
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("valid_%0d", k), {31'd0, obs_valid[k]}, {31'd0, exp_valid[k]});
            checkOutput($sformatf("data_%0d", k), obs_data[k], exp_data[k]);
        end
`ifdef DEMUX4_STATS_EN
        checkOutput("cnt_a", {28'd0, cnt_a}, {28'd0, exp_cnt[0]});
        checkOutput("cnt_b", {28'd0, cnt_b}, {28'd0, exp_cnt[1]});
        checkOutput("cnt_c", {28'd0, cnt_c}, {28'd0, exp_cnt[2]});
        checkOutput("cnt_d", {28'd0, cnt_d}, {28'd0, exp_cnt[3]});
`endif
    endtask

    initial begin
        exp_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            exp_data[k] = '0;
            exp_cnt[k]  = '0;
        end
        rst         = 1'b1;
        in_sel      = 2'd0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
        out_c_ready = 1'b0;
        out_d_ready = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b1, 2'd0, 32'h0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 2'd0, 32'h0, 1'b0, 4'b0000);

        $display("[TB] single word to c, then held under back-pressure");
        applyStimulus(1'b0, 2'd2, 32'hDEADBEEF, 1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'd2, 32'h0, 1'b0, 4'b0000);
        end

        $display("[TB] full c refuses, a accepts");
        applyStimulus(1'b0, 2'd2, 32'h11, 1'b1, 4'b0000);
        applyStimulus(1'b0, 2'd0, 32'h11, 1'b1, 4'b0000);

        $display("[TB] drain, then stream 8 words to b");
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 2'd1, 32'(i), 1'b1, 4'b1111);
        end
        applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 4'b1111);

        $display("[TB] round-robin fill, refuse, drain-and-accept on a");
        applyStimulus(1'b0, 2'd0, 32'd10, 1'b1, 4'b0000);
        applyStimulus(1'b0, 2'd1, 32'd20, 1'b1, 4'b0000);
        applyStimulus(1'b0, 2'd2, 32'd30, 1'b1, 4'b0000);
        applyStimulus(1'b0, 2'd3, 32'd40, 1'b1, 4'b0000);
        applyStimulus(1'b0, 2'd0, 32'd50, 1'b1, 4'b0000);
        applyStimulus(1'b0, 2'd0, 32'd50, 1'b1, 4'b0001);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b0000);

        $display("[TB] reset while full with in_valid high");
        applyStimulus(1'b1, 2'd1, 32'd99, 1'b1, 4'b0000);
        applyStimulus(1'b0, 2'd1, 32'd0, 1'b0, 4'b0000);

        $display("[TB] 17 transfers to d");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 2'd3, 32'(100 + i), 1'b1, 4'b1000);
        end
        applyStimulus(1'b0, 2'd3, 32'd0, 1'b0, 4'b1000);
        applyStimulus(1'b1, 2'd0, 32'd0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
